// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cosine datapath: default widths, the 1/K
// seed for x0 and the Q2.19 arctangent table the caller walks through.
package cordic_pkg;
  localparam int CORDIC_WORD_LENGTH = 21;
  localparam int CORDIC_ITER_WIDTH  = 5;
  localparam int CORDIC_LUT_DEPTH   = 17;

  localparam logic [CORDIC_WORD_LENGTH-1:0] CORDIC_INV_K = 21'h04DBA7;

  // atan(2^-i) * 2^19, rounded to nearest
  localparam logic [CORDIC_WORD_LENGTH-1:0] CORDIC_ATAN_LUT [CORDIC_LUT_DEPTH] = '{
    21'h06487F, 21'h03B58D, 21'h01F5B7, 21'h00FEAE,
    21'h007FD5, 21'h003FFB, 21'h001FFF, 21'h001000,
    21'h000800, 21'h000400, 21'h000200, 21'h000100,
    21'h000080, 21'h000040, 21'h000020, 21'h000010,
    21'h000008
  };
endpackage

// File: rtl/cordic_addsub.sv
// Signed add/subtract used for each CORDIC axis; wraps by default, clamps to
// the signed range when CORDIC_SATURATE_EN is defined.
module cordic_addsub #(
  parameter int WORD_LENGTH = 21
) (
  input  logic [WORD_LENGTH-1:0] a_i,
  input  logic [WORD_LENGTH-1:0] b_i,
  input  logic                   sub_i,
  output logic [WORD_LENGTH-1:0] sum_o
);
  logic [WORD_LENGTH-1:0] b_eff;
  logic [WORD_LENGTH-1:0] raw;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign raw   = a_i + b_eff + {{(WORD_LENGTH-1){1'b0}}, sub_i};

`ifdef CORDIC_SATURATE_EN
  logic ovf;
  // Same-sign operands producing an opposite-sign result means overflow;
  // the direction follows the operand sign.
  assign ovf   = (a_i[WORD_LENGTH-1] == b_eff[WORD_LENGTH-1]) &&
                 (raw[WORD_LENGTH-1] != a_i[WORD_LENGTH-1]);
  assign sum_o = !ovf ? raw :
                 a_i[WORD_LENGTH-1] ? {1'b1, {(WORD_LENGTH-1){1'b0}}}
                                    : {1'b0, {(WORD_LENGTH-1){1'b1}}};
`else
  assign sum_o = raw;
`endif
endmodule

// File: rtl/cordic_iteration.sv
// One rotation-mode CORDIC micro-rotation with registered outputs.
// Optional CORDIC_SATURATE_EN makes the three adders saturate instead of wrap.
module cordic_iteration
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = CORDIC_WORD_LENGTH,
  parameter int ITER_WIDTH  = CORDIC_ITER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [WORD_LENGTH-1:0] x_i,
  input  logic [WORD_LENGTH-1:0] y_i,
  input  logic [WORD_LENGTH-1:0] z_i,
  input  logic [WORD_LENGTH-1:0] alpha_i,
  input  logic [ITER_WIDTH-1:0]  iteration_i,
  output logic                   valid_o,
  output logic [WORD_LENGTH-1:0] next_x_o,
  output logic [WORD_LENGTH-1:0] next_y_o,
  output logic [WORD_LENGTH-1:0] next_z_o
);
  logic [WORD_LENGTH-1:0] xs, ys;
  logic [WORD_LENGTH-1:0] x_rot, y_rot, z_rot;
  logic                   z_neg;

  logic [WORD_LENGTH-1:0] next_x_d, next_y_d, next_z_d;
  logic [WORD_LENGTH-1:0] next_x_q, next_y_q, next_z_q;
  logic                   valid_d, valid_q;

  // Shifts past the word width sign-fill to 0 or all ones.
  assign xs    = $signed(x_i) >>> iteration_i;
  assign ys    = $signed(y_i) >>> iteration_i;
  assign z_neg = z_i[WORD_LENGTH-1];

  cordic_addsub #(.WORD_LENGTH(WORD_LENGTH)) u_add_x (
    .a_i(x_i), .b_i(ys), .sub_i(!z_neg), .sum_o(x_rot)
  );
  cordic_addsub #(.WORD_LENGTH(WORD_LENGTH)) u_add_y (
    .a_i(y_i), .b_i(xs), .sub_i(z_neg), .sum_o(y_rot)
  );
  cordic_addsub #(.WORD_LENGTH(WORD_LENGTH)) u_add_z (
    .a_i(z_i), .b_i(alpha_i), .sub_i(!z_neg), .sum_o(z_rot)
  );

  always_comb begin
    next_x_d = next_x_q;
    next_y_d = next_y_q;
    next_z_d = next_z_q;
    valid_d  = valid_i;
    if (valid_i) begin
      next_x_d = x_rot;
      next_y_d = y_rot;
      next_z_d = z_rot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      next_x_q <= '0;
      next_y_q <= '0;
      next_z_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      next_x_q <= next_x_d;
      next_y_q <= next_y_d;
      next_z_q <= next_z_d;
      valid_q  <= valid_d;
    end
  end

  assign next_x_o = next_x_q;
  assign next_y_o = next_y_q;
  assign next_z_o = next_z_q;
  assign valid_o  = valid_q;
endmodule

// File: tb/tb_cordic_iteration.sv
// Scoreboard bench for cordic_iteration: expected (x,y,z) computed with
// integer arithmetic at drive time, compared when valid_o shows up.
module tb_cordic_iteration;
  import cordic_pkg::*;
  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] x_i = '0, y_i = '0, z_i = '0, alpha_i = '0;
  logic [4:0]   iteration_i = '0;
  logic         valid_o;
  logic [W-1:0] next_x_o, next_y_o, next_z_o;

  int checks = 0;
  int errors = 0;
  logic [3*W-1:0] exp_q[$];
  logic [3*W-1:0] last_exp = '0;

  always #5 clk = ~clk;

  cordic_iteration dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .alpha_i(alpha_i),
    .iteration_i(iteration_i),
    .valid_o(valid_o), .next_x_o(next_x_o), .next_y_o(next_y_o),
    .next_z_o(next_z_o)
  );

  function automatic logic [W-1:0] fit(int r);
`ifdef CORDIC_SATURATE_EN
    if (r > 1048575)  r = 1048575;
    if (r < -1048576) r = -1048576;
`endif
    return r[W-1:0];
  endfunction

  function automatic logic [3*W-1:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                           logic [W-1:0] z, logic [W-1:0] a,
                                           logic [4:0] i);
    int sx, sy, sz, sa, xs, ys, rx, ry, rz;
    sx = $signed(x); sy = $signed(y); sz = $signed(z); sa = $signed(a);
    xs = sx >>> i;
    ys = sy >>> i;
    if (sz < 0) begin
      rx = sx + ys; ry = sy - xs; rz = sz + sa;
    end else begin
      rx = sx - ys; ry = sy + xs; rz = sz - sa;
    end
    return {fit(rx), fit(ry), fit(rz)};
  endfunction

  // Scoreboard: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got %h_%h_%h with nothing expected",
                 next_x_o, next_y_o, next_z_o);
      end else begin
        logic [3*W-1:0] e;
        e = exp_q.pop_front();
        if ({next_x_o, next_y_o, next_z_o} !== e) begin
          errors++;
          $display("FAIL result: got x=%h y=%h z=%h expected x=%h y=%h z=%h",
                   next_x_o, next_y_o, next_z_o, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] z, input logic [W-1:0] a,
                       input logic [4:0] i);
    @(negedge clk);
    valid_i = 1'b1; x_i = x; y_i = y; z_i = z; alpha_i = a; iteration_i = i;
    last_exp = model(x, y, z, a, i);
    exp_q.push_back(last_exp);
  endtask

  task automatic idle_and_drain(input string name);
    int n;
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, 0 required", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 1'b1; x_i = 21'h012345; y_i = 21'h054321; z_i = 21'h001111;
    alpha_i = CORDIC_ATAN_LUT[0]; iteration_i = 5'd3;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_o, next_x_o, next_y_o, next_z_o} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b x=%h y=%h z=%h, all zero required",
               valid_o, next_x_o, next_y_o, next_z_o);
    end
    valid_i = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    drive(CORDIC_INV_K, 21'h0, 21'h0, CORDIC_ATAN_LUT[0], 5'd0);
    drive(CORDIC_INV_K, CORDIC_INV_K, 21'h1B7781, CORDIC_ATAN_LUT[1], 5'd1);
    drive(21'h0, 21'h1FFFF0, 21'h0, 21'h0, 5'd2);
    drive(21'h0, 21'h1FFFF0, 21'h0, 21'h0, 5'd25);
    drive(21'h0FFFFF, 21'h0FFFFF, 21'h0, 21'h0, 5'd0);
    drive(21'h100000, 21'h100000, 21'h100000, 21'h0FFFFF, 5'd0);
    drive(21'h0ABCDE, 21'h1F0000, 21'h1FFFFF, 21'h000008, 5'd31);
    idle_and_drain("directed");
  endtask

  // Spot-check absolute values from hand-worked cases, independent of the model.
  task automatic test_known_values();
    drive(CORDIC_INV_K, CORDIC_INV_K, 21'h1B7781, CORDIC_ATAN_LUT[1], 5'd1);
    idle_and_drain("known");
    checks++;
    if ({next_x_o, next_y_o, next_z_o} !== {21'h07497A, 21'h026DD4, 21'h1F2D0E}) begin
      errors++;
      $display("FAIL known_negz: got %h %h %h expected 07497a 026dd4 1f2d0e",
               next_x_o, next_y_o, next_z_o);
    end
    drive(21'h0, 21'h1FFFF0, 21'h0, 21'h0, 5'd25);
    idle_and_drain("known");
    checks++;
    if (next_x_o !== 21'h000001) begin
      errors++;
      $display("FAIL known_bigshift: got x=%h expected 000001", next_x_o);
    end
    drive(21'h0FFFFF, 21'h0FFFFF, 21'h0, 21'h0, 5'd0);
    idle_and_drain("known");
    checks++;
`ifdef CORDIC_SATURATE_EN
    if ({next_x_o, next_y_o} !== {21'h0, 21'h0FFFFF}) begin
`else
    if ({next_x_o, next_y_o} !== {21'h0, 21'h1FFFFE}) begin
`endif
      errors++;
      $display("FAIL known_overflow: got x=%h y=%h", next_x_o, next_y_o);
    end
  endtask

  task automatic test_hold();
    drive(21'h03C0DE, 21'h1ACE00, 21'h004000, CORDIC_ATAN_LUT[4], 5'd4);
    idle_and_drain("hold");
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_o, next_x_o, next_y_o, next_z_o} !== {1'b0, last_exp}) begin
      errors++;
      $display("FAIL hold: got v=%b %h_%h_%h expected v=0 %h", valid_o,
               next_x_o, next_y_o, next_z_o, last_exp);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    for (int k = 0; k < 40; k++)
      drive($urandom, $urandom, $urandom, CORDIC_ATAN_LUT[$urandom_range(0, 16)],
            5'($urandom_range(0, 31)));
    // The last drive's result must be visible one cycle later with valid high.
    @(negedge clk);
    valid_i = 1'b0;
    seen = (valid_o === 1'b1) ? 1 : 0;
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL b2b_valid: valid_o=%b, 1 required", valid_o);
    end
    idle_and_drain("b2b");
  endtask

  task automatic test_mid_reset();
    drive(21'h011111, 21'h022222, 21'h033333, CORDIC_ATAN_LUT[2], 5'd2);
    drive(21'h044444, 21'h055555, 21'h066666, CORDIC_ATAN_LUT[3], 5'd3);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    checks++;
    if ({valid_o, next_x_o, next_y_o, next_z_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b x=%h y=%h z=%h, all zero required",
               valid_o, next_x_o, next_y_o, next_z_o);
    end
    valid_i = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_known_values();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_directed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
